dtype_ff: RTL and testbench
===========================

# dtype_ff

Parameterised D-type register with active-high clock enable and asynchronous active-high preset. It is the basic storage element of the sequential-circuits library. Flops, pipeline stages and state registers instantiate it wherever a value must be held across cycles and forced to a known value on reset. WIDTH=1 gives the classic single D flip-flop.

## Interface
- WIDTH, default 1: number of stored bits; legal range 1 to 64.
- PRESET_VAL, default all ones ({WIDTH{1'b1}}): value loaded by `pre`.
- clk  input  1  clock; all state changes except preset happen on the rising edge.
- pre  input  1  reset. One clock; reset is asynchronous and active-high. While high, q = PRESET_VAL.
- d  input  WIDTH  data to capture.
- e  input  1  clock enable, active-high.
- q  output  WIDTH  registered state.
- Positional port order (fixed, existing instantiations depend on it): d, e, clk, pre, q [, qn].

## Operation
- pre = 1: q is forced to PRESET_VAL immediately, without waiting for a clock edge. d, e and clk are ignored.
- pre = 0, rising clk edge, e = 1: q <= d, bit for bit.
- pre = 0, rising clk edge, e = 0: q holds its value.
- Falling clk edges never change q.
- X/Z on d with e = 1 propagates to q. X on e leaves q unknown in simulation; no X-masking logic.
- Before the first preset, q is undefined. The system must assert pre at power-up.
- Preset has priority over enable and data in every case.

## Timing
- Capture latency: 1 rising edge. The d value sampled at edge N is visible on q after edge N (within clock-to-q) and is held until the next enabled edge.
- Preset assertion: q reaches PRESET_VAL combinationally, with no clock needed and zero clock-cycle latency.
- Preset deassertion: synchronous release is not required. pre must fall at least one setup time before a rising edge; benches release it on a falling edge. The first rising edge after release with e = 1 captures d.
- Preset asserted mid-operation: the current q is discarded at once and no pending capture survives. After release, the flop resumes from PRESET_VAL.
- e and d must meet setup/hold around the rising edge; e changing on the falling edge is legal.
- There is no handshake and no back-pressure. An output is valid whenever pre = 0 and at least one enabled capture or preset has occurred.

## Configuration
- DTYPE_FF_QN_EN defined: adds a port `qn  output  WIDTH` after q, with qn = ~q at all times, including during preset (qn = ~PRESET_VAL).
- DTYPE_FF_QN_EN undefined: no qn port. The port list is exactly d, e, clk, pre, q.

## Structure
- Shared package `seq_pkg`:
  - constant DTYPE_FF_MAX_WIDTH = 64;
  - a typedef for the default preset pattern.
- One natural sub-module, `dtype_ff_bit`:
  - single-bit flop with d, e, clk, pre, q and a per-bit preset value;
  - dtype_ff instantiates WIDTH of these in a generate loop.
- Elaboration-time check: WIDTH must be between 1 and DTYPE_FF_MAX_WIDTH, else error.

## Test plan
- Power-up preset, WIDTH=1: with pre = 1 and d, e unknown, q = 1 within the same time step. With clock running and pre held 1 for 2 cycles, q stays 1.
- Enable low: release pre on a falling edge with e = 0 and d toggling 0/1 for 3 cycles -> q stays 1 throughout.
- Capture: with e = 1, drive d with a random 0/1 sequence for 10 cycles, changing on falling edges. At each rising edge q equals the d sampled there, and q is stable between edges.
- Async preset mid-stream: with q = 0 and e = 1, raise pre halfway through a clock-high phase -> q = 1 immediately. Drop pre on a falling edge with d = 0 -> q = 0 after the next rising edge.
- Wide/preset value, WIDTH=8, PRESET_VAL=8'hA5:
  - preset -> q = 8'hA5;
  - capture d = 8'h3C -> q = 8'h3C;
  - e = 0 with d = 8'hFF -> q holds 8'h3C.
- DTYPE_FF_QN_EN build: qn = ~q through the preset, capture and hold steps above (e.g. q = 8'h3C -> qn = 8'hC3).

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants and types for the sequential-circuits library.
package seq_pkg;

  localparam int unsigned DTYPE_FF_MAX_WIDTH = 64;

  typedef logic [DTYPE_FF_MAX_WIDTH-1:0] dtype_ff_preset_t;

  localparam dtype_ff_preset_t DTYPE_FF_PRESET_ONES = '1;

  // True when a register width is inside the supported range.
  function automatic bit dtype_ff_width_ok(int unsigned w);
    return (w >= 1) && (w <= DTYPE_FF_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/dtype_ff_bit.sv
// Single-bit D flop with clock enable and asynchronous active-high preset.
module dtype_ff_bit #(
  parameter logic PRESET_BIT = 1'b1
) (
  input  logic d,
  input  logic e,
  input  logic clk,
  input  logic pre,
  output logic q
);

  logic q_q;
  logic q_d;

  // Mux instead of an if() so an X enable stays visible as X on q.
  always_comb begin
    q_d = q_q;
    q_d = e ? d : q_q;
  end

  always_ff @(posedge clk or posedge pre) begin
    if (pre) begin
      q_q <= PRESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/dtype_ff.sv
// Parameterised D register with clock enable and async active-high preset.
// Define DTYPE_FF_QN_EN to add the inverted output port qn.
module dtype_ff
  import seq_pkg::*;
#(
  parameter int unsigned       WIDTH      = 1,
  parameter logic [WIDTH-1:0]  PRESET_VAL = WIDTH'(DTYPE_FF_PRESET_ONES)
) (
  input  logic [WIDTH-1:0] d,
  input  logic             e,
  input  logic             clk,
  input  logic             pre,
  output logic [WIDTH-1:0] q
`ifdef DTYPE_FF_QN_EN
  ,
  output logic [WIDTH-1:0] qn
`endif
);

  if (!dtype_ff_width_ok(WIDTH)) begin : g_width_check
    $error("dtype_ff: WIDTH=%0d outside 1..%0d", WIDTH, DTYPE_FF_MAX_WIDTH);
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    dtype_ff_bit #(
      .PRESET_BIT (PRESET_VAL[i])
    ) u_bit (
      .d   (d[i]),
      .e   (e),
      .clk (clk),
      .pre (pre),
      .q   (q[i])
    );
  end

`ifdef DTYPE_FF_QN_EN
  // Derived from q so it tracks preset combinationally as well.
  assign qn = ~q;
`endif

endmodule

// File: tb/tb_dtype_ff.sv
// Self-checking bench for dtype_ff: WIDTH=1 default and WIDTH=8, PRESET_VAL=8'hA5.
module tb_dtype_ff;

  localparam logic [7:0] P8 = 8'hA5;

  logic       clk = 1'b0;
  logic       pre = 1'b0;
  logic       e;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [7:0] d8;
  logic [7:0] q8;
`ifdef DTYPE_FF_QN_EN
  logic [0:0] qn1;
  logic [7:0] qn8;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: what the spec says each register should hold now.
  logic [0:0] m1;
  logic [7:0] m8;

  always #5 clk = ~clk;

  dtype_ff u_dut1 (
    .d   (d1),
    .e   (e),
    .clk (clk),
    .pre (pre),
    .q   (q1)
`ifdef DTYPE_FF_QN_EN
    , .qn (qn1)
`endif
  );

  dtype_ff #(.WIDTH(8), .PRESET_VAL(P8)) u_dut8 (
    .d   (d8),
    .e   (e),
    .clk (clk),
    .pre (pre),
    .q   (q8)
`ifdef DTYPE_FF_QN_EN
    , .qn (qn8)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".q1"}, 64'(q1), 64'(m1));
    check({tag, ".q8"}, 64'(q8), 64'(m8));
`ifdef DTYPE_FF_QN_EN
    check({tag, ".qn1"}, 64'(qn1), 64'(~m1));
    check({tag, ".qn8"}, 64'(qn8), 64'(~m8));
`endif
  endtask

  // One clock cycle: verify hold across the falling edge, drive, then verify capture.
  task automatic step(input string tag, input logic p, input logic en,
                      input logic [0:0] v1, input logic [7:0] v8);
    @(negedge clk);
    check_all({tag, ".negedge"});
    pre = p;
    e   = en;
    d1  = v1;
    d8  = v8;
    @(posedge clk);
    if (p) begin
      m1 = 1'b1;
      m8 = P8;
    end else if (en) begin
      m1 = v1;
      m8 = v8;
    end
    #1;
    check_all({tag, ".posedge"});
  endtask

  initial begin
    e  = 1'bx;
    d1 = 1'bx;
    d8 = 8'hxx;

    // Power-up preset with unknown data/enable, before any clock edge.
    #1 pre = 1'b1;
    m1 = 1'b1;
    m8 = P8;
    #1 check_all("powerup");

    for (int i = 0; i < 2; i++) step("pre_held", 1'b1, 1'bx, 1'bx, 8'hxx);

    for (int i = 0; i < 3; i++)
      step("en_low", 1'b0, 1'b0, 1'(i % 2), 8'(i * 8'h55));

    for (int i = 0; i < 10; i++)
      step("capture", 1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));

    step("zero", 1'b0, 1'b1, 1'b0, 8'h3C);

    // Preset in the middle of the clock-high phase.
    @(posedge clk);
    #2 pre = 1'b1;
    m1 = 1'b1;
    m8 = P8;
    #1 check_all("midpre");

    step("release", 1'b0, 1'b1, 1'b0, 8'h3C);
    step("hold_ff", 1'b0, 1'b0, 1'b1, 8'hFF);

    for (int i = 0; i < 12; i++)
      step("mixed", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    step("final_pre", 1'b1, 1'b1, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
